// File: rtl/ahb_pkg.sv
// ============================================================================
// ahb_pkg : shared AHB transfer/burst types, master IDs and burst length helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package ahb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'd0,
    HT_BUSY   = 2'd1,
    HT_NONSEQ = 2'd2,
    HT_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } hburst_t;

  localparam logic [3:0] MST_CPU  = 4'd1;
  localparam logic [3:0] MST_UART = 4'd2;

  // Beats remaining after the NONSEQ; zero means the burst never holds the bus.
  function automatic logic [3:0] burst_beats(input hburst_t b);
    case (b)
      HB_WRAP4,  HB_INCR4:  return 4'd3;
      HB_WRAP8,  HB_INCR8:  return 4'd7;
      HB_WRAP16, HB_INCR16: return 4'd15;
      default:              return 4'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_burst_counter.sv
// ============================================================================
// ahb_burst_counter : tracks remaining beats of the owner's fixed-length burst
// Revision: 1.0
// ============================================================================
`default_nettype none

module ahb_burst_counter
  import ahb_pkg::*;
(
  input  logic    HCLK,
  input  logic    HRESET,
  input  htrans_t HTRANS,
  input  hburst_t HBURST,
  input  logic    HREADY,
  output logic    burst_hold
);

  logic [3:0] r_beats_left;
  logic       w_fixed_start;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_beats_left <= 4'd0;
    end else if (HREADY) begin
      case (HTRANS)
        HT_NONSEQ: r_beats_left <= burst_beats(HBURST);
        HT_SEQ:    if (r_beats_left != 4'd0) r_beats_left <= r_beats_left - 4'd1;
        HT_IDLE:   r_beats_left <= 4'd0;
        default:   r_beats_left <= r_beats_left;
      endcase
    end
  end

  assign w_fixed_start = (HTRANS == HT_NONSEQ) && (burst_beats(HBURST) != 4'd0);

  // The last beat only releases the bus when it is actually a SEQ being accepted.
  assign burst_hold = w_fixed_start
                   || (r_beats_left > 4'd1)
                   || ((r_beats_left == 4'd1) && (HTRANS != HT_SEQ));

endmodule

`default_nettype wire

// File: rtl/ahb_arbiter.sv
// ============================================================================
// ahb_arbiter : two-master round-robin AHB arbiter with burst and lock hold
// Revision: 1.0
// ============================================================================
`default_nettype none

module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int DEFAULT_MASTER = 1
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       HBUSREQ1,
  input  logic       HBUSREQ2,
  input  logic       HLOCK1,
  input  logic       HLOCK2,
  input  logic [1:0] HTRANS,
  input  logic [2:0] HBURST,
  input  logic       HREADY,
  output logic       HGRANT1,
  output logic       HGRANT2,
  output logic [3:0] HMASTER,
  output logic       HMASTLOCK
);

  localparam logic [1:0] c_default_grant = (DEFAULT_MASTER == 2) ? 2'b10 : 2'b01;
  localparam logic [3:0] c_default_id    = (DEFAULT_MASTER == 2) ? MST_UART : MST_CPU;

  // Grant held one-hot: bit0 = CPU, bit1 = UART.
  logic [1:0] r_grant;
  logic [3:0] r_last;
  logic [3:0] r_master;
  logic       r_mastlock;

  logic       w_burst_hold;
  logic       w_lock_req;
  logic       w_arb_ok;
  logic [3:0] w_gnt_id;
  logic [1:0] w_next_grant;
  logic [3:0] w_next_last;

  ahb_burst_counter u_burst_counter (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .HTRANS     (htrans_t'(HTRANS)),
    .HBURST     (hburst_t'(HBURST)),
    .HREADY     (HREADY),
    .burst_hold (w_burst_hold)
  );

  assign w_gnt_id   = r_grant[1] ? MST_UART : MST_CPU;
  assign w_lock_req = r_grant[1] ? HLOCK2 : HLOCK1;
  assign w_arb_ok   = HREADY && !(w_lock_req || w_burst_hold);

  always_comb begin
    w_next_grant = r_grant;
    w_next_last  = r_last;
    if (w_arb_ok) begin
      if (HBUSREQ1 && HBUSREQ2) begin
        w_next_grant = (r_last == MST_CPU) ? 2'b10 : 2'b01;
        w_next_last  = (r_last == MST_CPU) ? MST_UART : MST_CPU;
      end else if (HBUSREQ1) begin
        w_next_grant = 2'b01;
        w_next_last  = MST_CPU;
      end else if (HBUSREQ2) begin
        w_next_grant = 2'b10;
        w_next_last  = MST_UART;
      end else begin
        // Parking is not a requested grant, so round-robin history is kept.
        w_next_grant = c_default_grant;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_grant    <= c_default_grant;
      r_last     <= MST_UART;
      r_master   <= c_default_id;
      r_mastlock <= 1'b0;
    end else if (HREADY) begin
      r_grant    <= w_next_grant;
      r_last     <= w_next_last;
      r_master   <= w_gnt_id;
      r_mastlock <= w_lock_req;
    end
  end

  assign HGRANT1   = r_grant[0];
  assign HGRANT2   = r_grant[1];
  assign HMASTER   = r_master;
  assign HMASTLOCK = r_mastlock;

endmodule

`default_nettype wire

// File: tb/tb_ahb_arbiter.sv
// ============================================================================
// tb_ahb_arbiter : scoreboard bench for ahb_arbiter against a behavioural model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ahb_arbiter;

  logic       HCLK = 1'b0;
  logic       HRESET = 1'b1;
  logic       HBUSREQ1 = 1'b0, HBUSREQ2 = 1'b0;
  logic       HLOCK1 = 1'b0, HLOCK2 = 1'b0;
  logic [1:0] HTRANS = 2'd0;
  logic [2:0] HBURST = 3'd0;
  logic       HREADY = 1'b0;
  logic       HGRANT1, HGRANT2;
  logic [3:0] HMASTER;
  logic       HMASTLOCK;

  ahb_arbiter #(.DEFAULT_MASTER(1)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .HBUSREQ1(HBUSREQ1), .HBUSREQ2(HBUSREQ2),
    .HLOCK1(HLOCK1), .HLOCK2(HLOCK2),
    .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY),
    .HGRANT1(HGRANT1), .HGRANT2(HGRANT2),
    .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic       g1;
    logic       g2;
    logic [3:0] mst;
    logic       lock;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: owner IDs as plain integers.
  int m_gnt, m_last, m_beats, m_mst, m_lock;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_gnt = 1; m_last = 2; m_beats = 0; m_mst = 1; m_lock = 0;
  endtask

  task automatic model_step(input bit r1, input bit r2, input bit l1, input bit l2,
                            input int tr, input int bu, input bit rdy);
    int lk;
    bit hold;
    int ng;
    if (!rdy) return;
    lk   = (m_gnt == 1) ? int'(l1) : int'(l2);
    hold = (lk != 0) || (tr == 2 && bu >= 2) || (m_beats > 1) || (m_beats == 1 && tr != 3);
    ng   = m_gnt;
    if (!hold) begin
      if (r1 && r2)  ng = 3 - m_last;
      else if (r1)   ng = 1;
      else if (r2)   ng = 2;
      else           ng = 1;
      if (r1 || r2) m_last = ng;
    end
    m_mst  = m_gnt;
    m_lock = lk;
    case (tr)
      0: m_beats = 0;
      2: m_beats = (bu >= 2) ? (2 << (bu >> 1)) - 1 : 0;
      3: if (m_beats > 0) m_beats = m_beats - 1;
      default: ;
    endcase
    m_gnt = ng;
  endtask

  // Drive one cycle of inputs and queue what the outputs must be after the edge.
  task automatic cyc(input bit r1, input bit r2, input bit l1, input bit l2,
                     input int tr, input int bu, input bit rdy);
    exp_t e;
    @(negedge HCLK);
    HBUSREQ1 = r1; HBUSREQ2 = r2; HLOCK1 = l1; HLOCK2 = l2;
    HTRANS = tr[1:0]; HBURST = bu[2:0]; HREADY = rdy;
    model_step(r1, r2, l1, l2, tr, bu, rdy);
    e.g1   = (m_gnt == 1);
    e.g2   = (m_gnt == 2);
    e.mst  = m_mst[3:0];
    e.lock = (m_lock != 0);
    q.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge HCLK);
    #2;
  endtask

  task automatic reset_mid();
    @(negedge HCLK);
    #2;
    HRESET = 1'b1;
    HREADY = 1'b0;
    #1;
    chk("rst_hgrant1", {3'b0, HGRANT1}, 4'd1);
    chk("rst_hgrant2", {3'b0, HGRANT2}, 4'd0);
    chk("rst_hmaster", HMASTER, 4'd1);
    chk("rst_hmastlock", {3'b0, HMASTLOCK}, 4'd0);
    q.delete();
    model_reset();
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge HCLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_hgrant1", {3'b0, HGRANT1}, {3'b0, e.g1});
        chk("sb_hgrant2", {3'b0, HGRANT2}, {3'b0, e.g2});
        chk("sb_hmaster", HMASTER, e.mst);
        chk("sb_hmastlock", {3'b0, HMASTLOCK}, {3'b0, e.lock});
        chk("sb_onehot", {3'b0, HGRANT1 ^ HGRANT2}, 4'd1);
      end
    end
  end

  initial begin : stim
    model_reset();
    @(negedge HCLK);
    @(negedge HCLK);
    chk("init_hgrant1", {3'b0, HGRANT1}, 4'd1);
    chk("init_hmaster", HMASTER, 4'd1);
    HRESET = 1'b0;

    // Lone UART request with the owner idle, then release.
    cyc(0, 1, 0, 0, 0, 0, 1);
    after_edge();
    chk("t2_grant2", {3'b0, HGRANT2}, 4'd1);
    cyc(0, 1, 0, 0, 0, 0, 1);
    after_edge();
    chk("t2_master", HMASTER, 4'd2);
    cyc(0, 0, 0, 0, 0, 0, 1);
    after_edge();
    chk("t2_return", {3'b0, HGRANT1}, 4'd1);

    // Asynchronous reset while HMASTER still points at the UART.
    reset_mid();

    // Continuous contention with SINGLE transfers alternates, CPU first.
    for (int k = 0; k < 4; k++) begin
      cyc(1, 1, 0, 0, 2, 0, 1);
      after_edge();
      chk("t3_alternate", {3'b0, HGRANT1}, (k % 2 == 0) ? 4'd1 : 4'd0);
    end

    // CPU INCR4 with two wait states on beat 2; handover on the last SEQ.
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 2, 3, 1); after_edge(); chk("t4_nonseq", {3'b0, HGRANT1}, 4'd1);
    cyc(1, 1, 0, 0, 3, 3, 1); after_edge(); chk("t4_seq1", {3'b0, HGRANT1}, 4'd1);
    cyc(1, 1, 0, 0, 3, 3, 0); after_edge(); chk("t4_wait1", {3'b0, HGRANT1}, 4'd1);
    cyc(1, 1, 0, 0, 3, 3, 0); after_edge(); chk("t4_wait2", {3'b0, HGRANT1}, 4'd1);
    cyc(1, 1, 0, 0, 3, 3, 1); after_edge(); chk("t4_seq2", {3'b0, HGRANT1}, 4'd1);
    cyc(1, 1, 0, 0, 3, 3, 1); after_edge(); chk("t4_seq3", {3'b0, HGRANT2}, 4'd1);

    // UART locked sequence blocks the CPU until HLOCK2 drops.
    cyc(1, 1, 0, 1, 0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 1, 0, 1, 2, 0, 1);
      after_edge();
      chk("t5_locked_grant", {3'b0, HGRANT2}, 4'd1);
      chk("t5_mastlock", {3'b0, HMASTLOCK}, 4'd1);
    end
    cyc(1, 1, 0, 0, 2, 0, 1);
    after_edge();
    chk("t5_release_grant", {3'b0, HGRANT1}, 4'd1);
    chk("t5_release_lock", {3'b0, HMASTLOCK}, 4'd0);

    // CPU INCR8 aborted by IDLE after two SEQ beats.
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 2, 5, 1);
    cyc(0, 1, 0, 0, 3, 5, 1);
    cyc(0, 1, 0, 0, 3, 5, 1);
    cyc(0, 1, 0, 0, 0, 5, 1);
    cyc(0, 1, 0, 0, 0, 0, 1);
    after_edge();
    chk("t6_abort_grant", {3'b0, HGRANT2}, 4'd1);

    // Reset in the middle of an INCR16.
    cyc(0, 1, 0, 0, 2, 7, 1);
    cyc(0, 1, 0, 0, 3, 7, 1);
    reset_mid();

    for (int k = 0; k < 1500; k++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
          ($urandom_range(0, 3) != 0));
    end
    after_edge();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
